// File: rtl/ws2812_chain_driver.sv
// -----------------------------------------------------------------------------
// ws2812_chain_driver
//
// WS2812B-family one-wire LED chain driver. Pixels arrive on a valid/ready
// stream into a one-entry holding register. From there they move into a shift
// register and are sent MSB first. Each bit is a high pulse of T0H or T1H
// cycles, padded low to exactly TBIT cycles. A frame is NUM_LEDS pixels
// followed by a TRESET-cycle low latch gap. If the next pixel is missing at a
// pixel boundary, the frame is cut short, the sticky underrun flag is set and
// the latch gap starts at once.
//
// Optional build macro: WS2812_ORDER_GRB_EN
//   defined   : pixel {R,G,B[,W]} is sent as {G,R,B[,W]} (native WS2812B order)
//   undefined : pixel bits are sent unmodified
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous reset, active high
//   pix_data_i    pixel word, sent MSB first
//   pix_valid_i   pix_data_i is valid
//   pix_ready_o   pixel accepted this cycle when pix_valid_i is also high
//   dout_o        registered one-wire serial output
//   busy_o        a frame is in progress, including its latch gap
//   frame_done_o  one-cycle pulse when a latch gap completes
//   underrun_o    sticky: a pixel was missing at a pixel boundary
// -----------------------------------------------------------------------------
module ws2812_chain_driver #(
   parameter int NUM_LEDS     = 8,
   parameter int BITS_PER_LED = 24,
   parameter int T0H          = 20,
   parameter int T1H          = 40,
   parameter int TBIT         = 63,
   parameter int TRESET       = 2750
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [BITS_PER_LED-1:0] pix_data_i,
   input  logic                    pix_valid_i,
   output logic                    pix_ready_o,
   output logic                    dout_o,
   output logic                    busy_o,
   output logic                    frame_done_o,
   output logic                    underrun_o
);

   localparam int TW = $clog2(TBIT + 1);
   localparam int LW = $clog2(TRESET + 1);
   localparam int PW = $clog2(NUM_LEDS + 1);
   localparam int IW = $clog2(BITS_PER_LED);

   // Last cycle index of each bit phase. The low phase pads the bit to TBIT.
   localparam logic [TW-1:0] T0H_END = TW'(T0H - 1);
   localparam logic [TW-1:0] T1H_END = TW'(T1H - 1);
   localparam logic [TW-1:0] T0L_END = TW'(TBIT - T0H - 1);
   localparam logic [TW-1:0] T1L_END = TW'(TBIT - T1H - 1);
   localparam logic [LW-1:0] LAT_END = LW'(TRESET - 1);
   localparam logic [PW-1:0] NUM_PIX = PW'(NUM_LEDS);
   localparam logic [IW-1:0] MSB_IDX = IW'(BITS_PER_LED - 1);

   // Illegal configurations stop elaboration.
   if (!(BITS_PER_LED == 24 || BITS_PER_LED == 32)) begin : g_bad_bpl
      $error("ws2812_chain_driver: BITS_PER_LED must be 24 or 32");
   end
   if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
      $error("ws2812_chain_driver: require 0 < T0H < T1H < TBIT");
   end
   if (NUM_LEDS < 1 || NUM_LEDS > 1024) begin : g_bad_leds
      $error("ws2812_chain_driver: NUM_LEDS must be 1..1024");
   end
   if (TRESET < 1) begin : g_bad_reset
      $error("ws2812_chain_driver: TRESET must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW,
      LATCH
   } state_e;

   state_e                  state_q, state_d;
   logic [BITS_PER_LED-1:0] hold_q, hold_d;
   logic                    hold_full_q, hold_full_d;
   logic [BITS_PER_LED-1:0] shift_q, shift_d;
   logic [IW-1:0]           bit_idx_q, bit_idx_d;
   logic [TW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [LW-1:0]           lat_cnt_q, lat_cnt_d;
   logic [PW-1:0]           sent_q, sent_d;
   logic [PW-1:0]           acc_q, acc_d;
   logic                    busy_q, busy_d;
   logic                    frame_done_q, frame_done_d;
   logic                    underrun_q, underrun_d;
   logic                    dout_q, dout_d;

   logic                    accept;
   logic [BITS_PER_LED-1:0] load_word;
   logic [TW-1:0]           high_end;
   logic [TW-1:0]           low_end;

`ifdef WS2812_ORDER_GRB_EN
   // Swap the two most significant bytes: {R,G,...} becomes {G,R,...}.
   assign load_word = {hold_q[BITS_PER_LED-9 -: 8],
                       hold_q[BITS_PER_LED-1 -: 8],
                       hold_q[BITS_PER_LED-17:0]};
`else
   assign load_word = hold_q;
`endif

   // Ready only depends on the holding register, the state and the frame
   // pixel budget, so an accept and a load of hold can never coincide.
   assign pix_ready_o = !rst_i && !hold_full_q && (state_q != LATCH) &&
                        (acc_q < NUM_PIX);
   assign accept      = pix_valid_i && pix_ready_o;

   assign high_end = shift_q[BITS_PER_LED-1] ? T1H_END : T0H_END;
   assign low_end  = shift_q[BITS_PER_LED-1] ? T1L_END : T0L_END;

   // NOTE: every next-state signal gets a default first, so no path through
   // the case statement leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      bit_cnt_d    = bit_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      sent_d       = sent_q;
      acc_d        = acc_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      underrun_d   = underrun_q;
      // dout follows the state one cycle late. The output is then a plain
      // flop, and every phase keeps its exact length.
      dout_d       = (state_q == HIGH);

      if (accept) begin
         hold_d      = pix_data_i;
         hold_full_d = 1'b1;
         acc_d       = acc_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               shift_d     = load_word;
               hold_full_d = 1'b0;
               bit_idx_d   = MSB_IDX;
               bit_cnt_d   = '0;
               sent_d      = sent_q + 1'b1;
               busy_d      = 1'b1;
               state_d     = HIGH;
            end
         end

         HIGH: begin
            if (bit_cnt_q == high_end) begin
               bit_cnt_d = '0;
               state_d   = LOW;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end

         LOW: begin
            if (bit_cnt_q == low_end) begin
               bit_cnt_d = '0;
               if (bit_idx_q != '0) begin
                  bit_idx_d = bit_idx_q - 1'b1;
                  shift_d   = shift_q << 1;
                  state_d   = HIGH;
               end else if (sent_q == NUM_PIX) begin
                  lat_cnt_d = '0;
                  state_d   = LATCH;
               end else if (hold_full_q) begin
                  // Gapless reload: the next pixel's first bit starts on the
                  // very next cycle, so the bit period stays TBIT.
                  shift_d     = load_word;
                  hold_full_d = 1'b0;
                  bit_idx_d   = MSB_IDX;
                  sent_d      = sent_q + 1'b1;
                  state_d     = HIGH;
               end else begin
                  // Feeder fell behind: truncate the frame and latch what
                  // was sent.
                  underrun_d = 1'b1;
                  lat_cnt_d  = '0;
                  state_d    = LATCH;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end

         LATCH: begin
            if (lat_cnt_q == LAT_END) begin
               lat_cnt_d    = '0;
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
               sent_d       = '0;
               acc_d        = '0;
               state_d      = IDLE;
            end else begin
               lat_cnt_d = lat_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments, so every flop samples
   // the values from before the edge, whatever order the statements run in.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // The pixel data registers are reset as well. Their contents are
         // never used while hold_full_q is clear, but a known value makes a
         // reset mid-frame easy to inspect.
         state_q      <= IDLE;
         hold_q       <= '0;
         hold_full_q  <= 1'b0;
         shift_q      <= '0;
         bit_idx_q    <= '0;
         bit_cnt_q    <= '0;
         lat_cnt_q    <= '0;
         sent_q       <= '0;
         acc_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
         dout_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         bit_cnt_q    <= bit_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         sent_q       <= sent_d;
         acc_q        <= acc_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
         dout_q       <= dout_d;
      end
   end

   assign dout_o       = dout_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;
   assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// -----------------------------------------------------------------------------
// tb_ws2812_chain_driver
//
// Directed and random frames for ws2812_chain_driver, using short bit timing.
// Outputs are sampled 1 time unit after each rising edge and stored per edge.
// A waveform model built from the pixel list predicts dout, busy and
// frame_done cycle by cycle. Each frame starts 2 edges after the first
// handshake. Each bit is Th high and then low up to TBIT. The frame ends with
// a TRESET low gap, and frame_done marks its end.
// Build with WS2812_ORDER_GRB_EN defined to exercise the 32-bit GRB variant.
// -----------------------------------------------------------------------------
module tb_ws2812_chain_driver;

   localparam int NUM_LEDS = 2;
`ifdef WS2812_ORDER_GRB_EN
   localparam int BPL = 32;
`else
   localparam int BPL = 24;
`endif
   localparam int T0H    = 2;
   localparam int T1H    = 4;
   localparam int TBIT   = 7;
   localparam int TRESET = 10;
   localparam int MAXC   = 8192;

   logic           clk = 1'b0;
   logic           rst;
   logic [BPL-1:0] pix_data;
   logic           pix_valid;
   logic           pix_ready;
   logic           dout;
   logic           busy;
   logic           frame_done;
   logic           underrun;

   ws2812_chain_driver #(
      .NUM_LEDS    (NUM_LEDS),
      .BITS_PER_LED(BPL),
      .T0H         (T0H),
      .T1H         (T1H),
      .TBIT        (TBIT),
      .TRESET      (TRESET)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .pix_data_i  (pix_data),
      .pix_valid_i (pix_valid),
      .pix_ready_o (pix_ready),
      .dout_o      (dout),
      .busy_o      (busy),
      .frame_done_o(frame_done),
      .underrun_o  (underrun)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic dout_w [MAXC];
   logic busy_w [MAXC];
   logic fd_w   [MAXC];
   logic ur_w   [MAXC];
   logic rdy_w  [MAXC];

   logic [BPL-1:0] feed_q[$];
   int             hs_edge[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      pix_valid = (feed_q.size() > 0);
      pix_data  = (feed_q.size() > 0) ? feed_q[0] : '0;
   endtask

   // One clock: note a handshake at the coming edge, then sample after it.
   task automatic cycle();
      logic hs;
      hs = pix_valid & pix_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < MAXC) begin
         dout_w[cyc] = dout;
         busy_w[cyc] = busy;
         fd_w[cyc]   = frame_done;
         ur_w[cyc]   = underrun;
         rdy_w[cyc]  = pix_ready;
      end
      if (hs === 1'b1) begin
         hs_edge.push_back(cyc);
         void'(feed_q.pop_front());
      end
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   // Order in which the pixel bytes appear on the wire.
   function automatic logic [BPL-1:0] wire_order(input logic [BPL-1:0] p);
      logic [BPL-1:0] w;
      w = p;
`ifdef WS2812_ORDER_GRB_EN
      w[BPL-1 -: 8] = p[BPL-9 -: 8];
      w[BPL-9 -: 8] = p[BPL-1 -: 8];
`endif
      return w;
   endfunction

   // Read back bits from recorded dout: a bit is 1 if its high time is T1H.
   function automatic logic [31:0] decode(input int start, input int nbits);
      logic [31:0] v;
      int          ones;
      int          idx;
      v = '0;
      for (int k = 0; k < nbits; k++) begin
         ones = 0;
         for (int j = 0; j < TBIT; j++) begin
            idx = start + k * TBIT + j;
            if (idx < MAXC && dout_w[idx] === 1'b1) ones++;
         end
         v = {v[30:0], (ones >= T1H)};
      end
      return v;
   endfunction

   // ur_mode: 0 = underrun stays clear, 1 = rises after last bit, 2 = ignore
   task automatic check_frame(input string name, input int h, input logic [BPL-1:0] pix[$],
                              input int ur_mode, output int f);
      int             bits[$];
      logic [BPL-1:0] w;
      int             b;
      int             rel;
      int             th;
      int             u;
      logic           ed;
      logic           eb;
      logic           ef;
      foreach (pix[i]) begin
         w = wire_order(pix[i]);
         for (int k = BPL - 1; k >= 0; k--) bits.push_back(int'(w[k]));
      end
      b = bits.size();
      f = h + 1 + b * TBIT + TRESET;
      if (f + 2 > cyc || f + 2 >= MAXC) begin
         check({name, " frame_complete"}, cyc, f + 2);
         return;
      end
      for (int s = h + 1; s <= f + 1; s++) begin
         rel = s - (h + 2);
         if (rel >= 0 && rel < b * TBIT) begin
            th = (bits[rel / TBIT] != 0) ? T1H : T0H;
            ed = ((rel % TBIT) < th);
         end else begin
            ed = 1'b0;
         end
         eb = (s < f);
         ef = (s == f);
         check($sformatf("%s wave+%0d {dout,busy,fd}", name, s - h),
               {29'd0, dout_w[s], busy_w[s], fd_w[s]}, {29'd0, ed, eb, ef});
      end
      u = h + 1 + b * TBIT;
      if (ur_mode == 0) begin
         check({name, " underrun_clear"}, ur_w[f], 0);
      end else if (ur_mode == 1) begin
         check({name, " underrun_before"}, ur_w[u - 1], 0);
         check({name, " underrun_set"}, ur_w[u], 1);
         check({name, " underrun_after"}, ur_w[f + 1], 1);
      end
   endtask

   task automatic run_and_check(input string name, input logic [BPL-1:0] pix[$],
                                input int ur_mode, output int h);
      int n0;
      int nh;
      int f;
      n0 = hs_edge.size();
      foreach (pix[i]) feed_q.push_back(pix[i]);
      drive();
      run(pix.size() * BPL * TBIT + TRESET + 6);
      nh = hs_edge.size() - n0;
      check({name, " hs_count"}, nh, pix.size());
      if (nh > 0) begin
         h = hs_edge[n0];
         check_frame(name, h, pix, ur_mode, f);
      end else begin
         h = cyc;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BPL-1:0] pq[$];
      logic [BPL-1:0] pa[$];
      logic [BPL-1:0] pb[$];
      int             h;
      int             n0;
      int             fa;
      int             fb;
      int             ones;

      // ---------------- reset state ----------------
      rst       = 1'b1;
      pix_valid = 1'b0;
      pix_data  = '0;
      run(3);
      pix_valid = 1'b1;
      pix_data  = BPL'(32'h00123456);
      #1;
      check("reset pix_ready", pix_ready, 0);
      check("reset dout", dout, 0);
      check("reset busy", busy, 0);
      check("reset frame_done", frame_done, 0);
      check("reset underrun", underrun, 0);
      rst = 1'b0;
      drive();
      run(2);
      check("idle pix_ready", rdy_w[cyc], 1);
      check("idle busy", busy_w[cyc], 0);

      // ---------------- two pixels back to back ----------------
      pq = '{BPL'(32'h00FF0000), BPL'(32'h00000001)};
      n0 = hs_edge.size();
      run_and_check("t1", pq, 0, h);
      if (hs_edge.size() >= n0 + 2) begin
         check("t1 second_accept_edge", hs_edge[n0 + 1] - h, 2);
      end
`ifndef WS2812_ORDER_GRB_EN
      check("t1 decoded_pixel0", decode(h + 2, 24), 32'h00FF0000);
      check("t1 decoded_pixel1", decode(h + 2 + 24 * TBIT, 24), 32'h00000001);
`endif

      // ---------------- random full frames ----------------
      for (int i = 0; i < 2; i++) begin
         pq = '{BPL'($urandom), BPL'($urandom)};
         run_and_check($sformatf("rand%0d", i), pq, 0, h);
         run($urandom_range(0, 5));
      end

      // ---------------- back-pressure through the latch gap ----------------
      pa = '{BPL'($urandom), BPL'($urandom)};
      pb = '{BPL'($urandom), BPL'($urandom)};
      n0 = hs_edge.size();
      foreach (pa[i]) feed_q.push_back(pa[i]);
      foreach (pb[i]) feed_q.push_back(pb[i]);
      drive();
      run(2 * (2 * BPL * TBIT + TRESET) + 12);
      check("bp hs_count", hs_edge.size() - n0, 4);
      if (hs_edge.size() >= n0 + 4) begin
         check_frame("bp_a", hs_edge[n0], pa, 0, fa);
         ones = 0;
         for (int s = fa - TRESET; s < fa; s++) ones += int'(rdy_w[s]);
         check("bp ready_during_gap", ones, 0);
         check("bp accept_after_done", hs_edge[n0 + 2], fa + 1);
         check("bp second_accept", hs_edge[n0 + 3] - hs_edge[n0 + 2], 2);
         check_frame("bp_b", hs_edge[n0 + 2], pb, 0, fb);
      end

      // ---------------- single pixel: handshake latency and underrun ----------------
      pq = '{BPL'(32'h00A5A5A5)};
      run_and_check("t2", pq, 1, h);
      check("t2 ready_drops_after_accept", rdy_w[h], 0);
      check("t2 dout_low_1_edge_after", dout_w[h + 1], 0);
      check("t2 dout_high_2_edges_after", dout_w[h + 2], 1);
`ifndef WS2812_ORDER_GRB_EN
      check("t2 decoded_pixel", decode(h + 2, 24), 32'h00A5A5A5);
`endif
      run(20);
      check("t3 underrun_sticky", underrun, 1);

      // ---------------- reset in the middle of a frame ----------------
      n0 = hs_edge.size();
      feed_q.push_back(BPL'($urandom) | {1'b1, {(BPL - 1){1'b0}}});
      drive();
      run(3);
      check("t4 hs_count", hs_edge.size() - n0, 1);
      h = (hs_edge.size() > n0) ? hs_edge[n0] : cyc;
      while (cyc < h + 2 + 4 * TBIT + 1) cycle();
      rst = 1'b1;
      cycle();
      check("t4 dout_after_rst", dout, 0);
      check("t4 busy_after_rst", busy, 0);
      check("t4 ready_in_rst", pix_ready, 0);
      check("t4 underrun_cleared", underrun, 0);
      cycle();
      check("t4 dout_held_low", dout, 0);
      rst = 1'b0;
      run(2);
      pq = '{BPL'(32'h00800000)};
      run_and_check("t4_after", pq, 1, h);
`ifndef WS2812_ORDER_GRB_EN
      check("t4 decoded_pixel", decode(h + 2, 24), 32'h00800000);
`endif

`ifdef WS2812_ORDER_GRB_EN
      // ---------------- GRB reorder, RGBW word ----------------
      pq = '{BPL'(32'h11223344)};
      run_and_check("t6", pq, 2, h);
      check("t6 decoded_grb", decode(h + 2, 32), 32'h22113344);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ws2812_chain_driver.md
Name: ws2812_chain_driver

Overview:
Parametrised WS2812B-family serial LED driver, the successor to the fixed single-string driver behind the I2C front end. It accepts pixels on a valid/ready stream and serialises them MSB-first with programmable one-wire bit timing. Each frame carries NUM_LEDS pixels and ends with a latch/reset gap. It supports RGB (24-bit) and RGBW (32-bit) strings, and reports underruns, so the I2C register block or a DMA-style feeder can drive long chains.

Parameters:
NUM_LEDS, 8, pixels per frame (1..1024)
BITS_PER_LED, 24, pixel width; 24 (RGB) or 32 (RGBW); any other value is an elaboration error
T0H, 20, high time of a '0' bit in clk cycles (400 ns at 50 MHz)
T1H, 40, high time of a '1' bit in clk cycles (800 ns at 50 MHz)
TBIT, 63, total bit period in clk cycles; elaboration check requires 0<T0H<T1H<TBIT
TRESET, 2750, latch gap in clk cycles (55 us at 50 MHz); must be >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high; sampled on the rising edge of clk
pix_data  in  BITS_PER_LED  pixel word, sent MSB first
pix_valid  in  1  pix_data is valid
pix_ready  out  1  driver accepts pix_data this cycle (transfer = valid & ready)
dout  out  1  one-wire serial output to the LED chain
busy  out  1  high from first pixel accepted until the latch gap completes
frame_done  out  1  one-cycle pulse when the latch gap of a frame ends
underrun  out  1  sticky flag: a pixel was not available at a pixel boundary

Behaviour:
- Reset (rst=1 at an edge): state IDLE, all counters 0, holding register empty. Outputs: dout=0, busy=0, frame_done=0, underrun=0, pix_ready=0 during reset.
- Reset mid-frame aborts the frame immediately: dout=0 on the next cycle, with no partial latch gap.
- Storage: a one-entry holding register (hold, hold_full) plus a shift register. An accepted pixel is written to hold.
- pix_ready = !rst & !hold_full & (state != LATCH) & (accepted_count < NUM_LEDS).
- accepted_count resets to 0 on entry to IDLE.
- States:
  - IDLE: dout=0. If hold_full, move hold to the shift register, clear hold_full, set bit_idx=BITS_PER_LED-1, set busy, go to HIGH.
  - HIGH: dout=1 for Th cycles, where Th=T1H if the current bit is 1, else T0H. Then go to LOW.
  - LOW: dout=0 for TBIT-Th cycles. At the end of LOW:
    - If bit_idx>0: decrement bit_idx, shift left, go to HIGH.
    - Else, if pixels sent == NUM_LEDS: go to LATCH.
    - Else, if hold_full: load the next pixel and go to HIGH. This is gapless; the bit period stays exactly TBIT.
    - Else: set underrun=1 and go to LATCH. The frame is truncated and the pixel counter discards the rest.
  - LATCH: dout=0 for TRESET cycles. On the final cycle pulse frame_done=1, drop busy, go to IDLE.
- Latency: pix_valid&pix_ready at edge N gives hold_full at N. IDLE loads at edge N+1, and dout=1 is visible after edge N+2.
- dout is driven from a register; it is glitch-free and every bit is exactly TBIT cycles.
- An accept and a load of hold in the same cycle cannot happen, because pix_ready requires hold empty.
- A pixel offered while in LATCH waits (pix_ready=0) and starts the next frame from IDLE.
- underrun is cleared only by rst.
- Counter widths: $clog2(TRESET+1), $clog2(TBIT+1), $clog2(NUM_LEDS+1), $clog2(BITS_PER_LED). There is no wrap: every counter is bounded by its compare.

Optional Feature:
WS2812_ORDER_GRB_EN
- Defined: pix_data is taken as {R,G,B[,W]} and reordered to {G,R,B[,W]} when loaded into the shift register, so dout carries the native WS2812B GRB order.
- Undefined: pix_data bits are shifted out unmodified.
- Timing and handshake are identical in both builds.

Test Plan:
1. Bench parameters NUM_LEDS=2, T0H=2, T1H=4, TBIT=7, TRESET=10; send 0xFF0000 then 0x000001 back-to-back, feature off -> dout shows 8 high-pulses of 4 cycles, then 39 of 2 cycles, then a final 4-cycle pulse. Every bit is 7 cycles. After the last bit, 10 low cycles, then frame_done pulses once and busy falls.
2. Same parameters, single pixel 0xA5A5A5 with pix_valid held high -> pix_ready drops after the accept; dout rises exactly 2 edges after the handshake edge. Pulse pattern is 1010_0101 repeated.
3. Underrun: NUM_LEDS=2, send one pixel only -> after 24 bits underrun=1 and LATCH runs for 10 cycles. frame_done pulses; underrun stays 1 until rst.
4. Reset mid-frame: assert rst during bit 5 of pixel 0 -> next cycle dout=0, busy=0, pix_ready=0. After release, a new pixel 0x800000 serialises correctly from the MSB.
5. Back-pressure: pix_valid asserted during LATCH -> pix_ready=0 for the whole gap. The pixel is accepted in the cycle after frame_done and a new frame begins.
6. WS2812_ORDER_GRB_EN defined, BITS_PER_LED=32, pixel 0x11223344 -> dout bit sequence equals 0x22113344 MSB first.
